// File: rtl/sqrt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_controller_pkg
// Purpose  : Shared opcodes, register indices and FSM encoding for the
//            Newton-Raphson square-root controller.
// Revision : 1.0
// ============================================================================
package sqrt_controller_pkg;

    localparam int c_MAX_ITER_DEFAULT = 16;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    // r0, r5 and r6 hold constants and are never write targets
    localparam logic [2:0] c_R_ZERO = 3'd0;
    localparam logic [2:0] c_R_S    = 3'd1;
    localparam logic [2:0] c_R_X    = 3'd2;
    localparam logic [2:0] c_R_TEMP = 3'd3;
    localparam logic [2:0] c_R_XNEW = 3'd4;
    localparam logic [2:0] c_R_TWO  = 3'd5;
    localparam logic [2:0] c_R_EPS  = 3'd6;
    localparam logic [2:0] c_R_DIFF = 3'd7;

    localparam logic [2:0] c_STEP_LAST = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_S = 3'd1,
        S_LOAD_X = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_controller_if
// Purpose  : Controller <-> datapath (register file, FP ALU) signal bundle.
// Revision : 1.0
// ============================================================================
interface sqrt_controller_if;
    logic       start_i;
    logic       alu_done_i;
    logic       converged_i;
    logic [2:0] addr_rda_o;
    logic [2:0] addr_rdb_o;
    logic [2:0] addr_wr_o;
    logic       WE_o;
    logic       sel_ext_o;
    logic [1:0] alu_op_o;
    logic       alu_start_o;
    logic       busy_o;
    logic       done_o;
    logic [4:0] iter_o;

    modport master (
        input  start_i, alu_done_i, converged_i,
        output addr_rda_o, addr_rdb_o, addr_wr_o, WE_o, sel_ext_o,
               alu_op_o, alu_start_o, busy_o, done_o, iter_o
    );

    modport slave (
        output start_i, alu_done_i, converged_i,
        input  addr_rda_o, addr_rdb_o, addr_wr_o, WE_o, sel_ext_o,
               alu_op_o, alu_start_o, busy_o, done_o, iter_o
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_controller_step_decode.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_step_decode
// Purpose  : Maps a Newton step index to its ALU operands, target and opcode.
// Revision : 1.0
// ============================================================================
module sqrt_step_decode
    import sqrt_controller_pkg::*;
(
    input  logic [2:0] i_step,
    output logic [2:0] o_rda,
    output logic [2:0] o_rdb,
    output logic [2:0] o_wr,
    output logic [1:0] o_op
);

    // x_new = (S/x + x) / 2, diff = x_new - x, x = x_new
    always_comb begin
        o_rda = c_R_ZERO;
        o_rdb = c_R_ZERO;
        o_wr  = c_R_ZERO;
        o_op  = c_OP_ADD;
        case (i_step)
            3'd0: begin o_rda = c_R_S;    o_rdb = c_R_X;    o_wr = c_R_TEMP; o_op = c_OP_DIV; end
            3'd1: begin o_rda = c_R_X;    o_rdb = c_R_TEMP; o_wr = c_R_TEMP; o_op = c_OP_ADD; end
            3'd2: begin o_rda = c_R_TEMP; o_rdb = c_R_TWO;  o_wr = c_R_XNEW; o_op = c_OP_DIV; end
            3'd3: begin o_rda = c_R_XNEW; o_rdb = c_R_X;    o_wr = c_R_DIFF; o_op = c_OP_SUB; end
            3'd4: begin o_rda = c_R_XNEW; o_rdb = c_R_ZERO; o_wr = c_R_X;    o_op = c_OP_ADD; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sqrt_controller.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_controller
// Purpose  : Sequences register-file and FP-ALU traffic for an iterative
//            Newton-Raphson square root.
// Revision : 1.0
// ============================================================================
module sqrt_controller
    import sqrt_controller_pkg::*;
#(
    parameter int MAX_ITER = c_MAX_ITER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    sqrt_controller_if.master bus
);

    localparam logic [4:0] c_LAST_ITER = 5'(MAX_ITER - 1);

    state_t     r_state;
    logic [2:0] r_step;
    logic [4:0] r_iter;
    logic       r_sel_ext;
    logic       r_alu_start;
    logic       r_busy;
    logic       r_done;

    logic [2:0] w_dec_rda, w_dec_rdb, w_dec_wr;
    logic [1:0] w_dec_op;
    logic [2:0] w_rda, w_rdb, w_wr;
    logic [1:0] w_op;
    logic       w_we;

    sqrt_step_decode u_decode (
        .i_step (r_step),
        .o_rda  (w_dec_rda),
        .o_rdb  (w_dec_rdb),
        .o_wr   (w_dec_wr),
        .o_op   (w_dec_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= 3'd0;
            r_iter      <= 5'd0;
            r_sel_ext   <= 1'b0;
            r_alu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state   <= S_LOAD_S;
                        r_busy    <= 1'b1;
                        r_sel_ext <= 1'b1;
                    end
                end
                S_LOAD_S: r_state <= S_LOAD_X;
                S_LOAD_X: begin
                    r_state     <= S_ISSUE;
                    r_step      <= 3'd0;
                    r_iter      <= 5'd0;
                    r_sel_ext   <= 1'b0;
                    r_alu_start <= 1'b1;
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.alu_done_i) begin
                        if (r_step < c_STEP_LAST) begin
                            r_step      <= r_step + 3'd1;
                            r_state     <= S_ISSUE;
                            r_alu_start <= 1'b1;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.converged_i || (r_iter == c_LAST_ITER)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_iter      <= r_iter + 5'd1;
                        r_step      <= 3'd0;
                        r_state     <= S_ISSUE;
                        r_alu_start <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_sel_ext <= 1'b0;
                end
            endcase
        end
    end

    // Write enable follows alu_done_i within the same cycle, so it is decoded
    // from the registered state rather than registered itself.
    always_comb begin
        w_rda = c_R_ZERO;
        w_rdb = c_R_ZERO;
        w_wr  = c_R_ZERO;
        w_op  = c_OP_ADD;
        w_we  = 1'b0;
        case (r_state)
            S_LOAD_S: begin w_wr = c_R_S; w_we = 1'b1; end
            S_LOAD_X: begin w_wr = c_R_X; w_we = 1'b1; end
            S_ISSUE: begin
                w_rda = w_dec_rda; w_rdb = w_dec_rdb; w_wr = w_dec_wr; w_op = w_dec_op;
            end
            S_WAIT: begin
                w_rda = w_dec_rda; w_rdb = w_dec_rdb; w_wr = w_dec_wr; w_op = w_dec_op;
                w_we  = bus.alu_done_i;
            end
            S_CHECK: begin w_rda = c_R_DIFF; w_rdb = c_R_EPS; end
            S_DONE:  w_rda = c_R_X;
            default: ;
        endcase
    end

    assign bus.addr_rda_o  = w_rda;
    assign bus.addr_rdb_o  = w_rdb;
    assign bus.addr_wr_o   = w_wr;
    assign bus.alu_op_o    = w_op;
    assign bus.WE_o        = w_we;
    assign bus.sel_ext_o   = r_sel_ext;
    assign bus.alu_start_o = r_alu_start;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.iter_o      = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_controller
// Purpose  : Randomised scoreboard bench with an ALU/comparator environment.
// Revision : 1.0
// ============================================================================
module tb_sqrt_controller;
    import sqrt_controller_pkg::*;

    localparam int MAX_ITER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sqrt_controller_if bus ();

    sqrt_controller #(.MAX_ITER(MAX_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] addr; logic sel; } wr_t;
    typedef struct { logic [2:0] rda; logic [2:0] rdb; logic [1:0] op; } iss_t;
    typedef struct { int t0; int lat; logic [4:0] iter; } done_t;

    wr_t   wr_q[$];
    iss_t  is_q[$];
    done_t done_q[$];
    wr_t   w;
    iss_t  iss;
    done_t d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int alu_lat = 3;
    int conv_at = 0;
    bit spur = 1'b0;
    int alu_cnt = 0;
    int r2_writes = 0;
    int check_visits = 0;

    logic [20:0] all_out;
    assign all_out = {bus.addr_rda_o, bus.addr_rdb_o, bus.addr_wr_o, bus.WE_o, bus.sel_ext_o,
                      bus.alu_op_o, bus.alu_start_o, bus.busy_o, bus.done_o, bus.iter_o};

    always @(posedge clk) cyc++;

    // ALU with latency alu_lat, optional spurious done in the launch cycle;
    // comparator reports convergence once conv_at+1 updates of x have landed.
    initial begin
        bus.alu_done_i  = 1'b0;
        bus.converged_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.alu_done_i = 1'b0;
            if (rst) begin
                alu_cnt = 0;
            end else begin
                if (alu_cnt > 0) begin
                    alu_cnt--;
                    if (alu_cnt == 0) bus.alu_done_i = 1'b1;
                end
                if (bus.alu_start_o) begin
                    alu_cnt = alu_lat;
                    if (spur) bus.alu_done_i = 1'b1;
                end
            end
            bus.converged_i = (r2_writes > conv_at);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.alu_start_o) begin
                checks++;
                if (is_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected got rda=%0d rdb=%0d op=%0d required none",
                             bus.addr_rda_o, bus.addr_rdb_o, bus.alu_op_o);
                end else begin
                    iss = is_q.pop_front();
                    if (bus.addr_rda_o != iss.rda || bus.addr_rdb_o != iss.rdb || bus.alu_op_o != iss.op) begin
                        errors++;
                        $display("FAIL issue got rda=%0d rdb=%0d op=%0d required rda=%0d rdb=%0d op=%0d",
                                 bus.addr_rda_o, bus.addr_rdb_o, bus.alu_op_o, iss.rda, iss.rdb, iss.op);
                    end
                end
            end
            if (bus.WE_o) begin
                checks++;
                assert (!(bus.addr_wr_o inside {3'd0, 3'd5, 3'd6})) else begin
                    errors++;
                    $display("FAIL protected_write got addr=%0d required not in {0,5,6}", bus.addr_wr_o);
                end
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got addr=%0d sel=%0d required none",
                             bus.addr_wr_o, bus.sel_ext_o);
                end else begin
                    w = wr_q.pop_front();
                    if (bus.addr_wr_o != w.addr || bus.sel_ext_o != w.sel) begin
                        errors++;
                        $display("FAIL write got addr=%0d sel=%0d required addr=%0d sel=%0d",
                                 bus.addr_wr_o, bus.sel_ext_o, w.addr, w.sel);
                    end
                end
                if (bus.addr_wr_o == 3'd2 && !bus.sel_ext_o) r2_writes++;
            end
            if (bus.busy_o && !bus.WE_o && bus.addr_rda_o == 3'd7 && bus.addr_rdb_o == 3'd6) begin
                checks++;
                if (int'(bus.iter_o) != check_visits) begin
                    errors++;
                    $display("FAIL check_iter got %0d required %0d", bus.iter_o, check_visits);
                end
                check_visits++;
            end
            if (bus.done_o) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got done=1 required 0");
                end else begin
                    d = done_q.pop_front();
                    if (cyc - d.t0 != d.lat || bus.iter_o != d.iter || bus.addr_rda_o != 3'd2 ||
                        check_visits != int'(d.iter) + 1 || wr_q.size() != 0 || is_q.size() != 0) begin
                        errors++;
                        $display("FAIL done got lat=%0d iter=%0d rda=%0d visits=%0d left=%0d required lat=%0d iter=%0d rda=2 visits=%0d left=0",
                                 cyc - d.t0, bus.iter_o, bus.addr_rda_o, check_visits,
                                 wr_q.size() + is_q.size(), d.lat, d.iter, int'(d.iter) + 1);
                    end
                end
            end
        end
    end

    task automatic push_iteration();
        is_q.push_back('{3'd1, 3'd2, 2'd3});
        is_q.push_back('{3'd2, 3'd3, 2'd0});
        is_q.push_back('{3'd3, 3'd5, 2'd3});
        is_q.push_back('{3'd4, 3'd2, 2'd1});
        is_q.push_back('{3'd4, 3'd0, 2'd0});
        wr_q.push_back('{3'd3, 1'b0});
        wr_q.push_back('{3'd3, 1'b0});
        wr_q.push_back('{3'd4, 1'b0});
        wr_q.push_back('{3'd7, 1'b0});
        wr_q.push_back('{3'd2, 1'b0});
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run(input int lat, input int conv, input bit sp, input bit noise);
        int  k;
        int  t0;
        bit  seen;
        alu_lat      = lat;
        conv_at      = conv;
        spur         = sp;
        r2_writes    = 0;
        check_visits = 0;
        k = (conv + 1 < MAX_ITER) ? conv + 1 : MAX_ITER;
        wr_q.push_back('{3'd1, 1'b1});
        wr_q.push_back('{3'd2, 1'b1});
        for (int i = 0; i < k; i++) push_iteration();
        bus.start_i = 1'b1;
        t0 = cyc;
        done_q.push_back('{t0, 2 + k * (5 * (1 + lat) + 1) + 1, 5'(k - 1)});
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            bus.start_i = noise && ($urandom_range(0, 3) == 0);
            if (bus.done_o) seen = 1'b1;
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout got no done_o required done within 300 cycles");
            rst = 1'b1;
            wr_q.delete(); is_q.delete(); done_q.delete();
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end else if (all_out[20:5] != 16'd0) begin
            errors++;
            $display("FAIL idle_after_done got %h required 0000", all_out[20:5]);
        end
    endtask

    task automatic abort_test();
        int bad;
        bit found;
        alu_lat = 4; conv_at = 0; spur = 1'b0; r2_writes = 0; check_visits = 0;
        wr_q.push_back('{3'd1, 1'b1});
        wr_q.push_back('{3'd2, 1'b1});
        is_q.push_back('{3'd1, 3'd2, 2'd3});
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.alu_start_o) found = 1'b1;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!found || all_out != 21'd0) begin
            errors++;
            $display("FAIL abort_outputs got %h found_issue=%0d required 000000 found_issue=1", all_out, found);
        end
        wr_q.delete(); is_q.delete(); done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.WE_o || bus.done_o || bus.busy_o) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles required 0", bad);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (all_out != 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 000000", all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        run(3, 0, 1'b0, 1'b0);
        run(2, 99, 1'b0, 1'b0);
        run(2, 0, 1'b1, 1'b0);
        run(1, 1, 1'b0, 1'b1);
        for (int r = 0; r < 20; r++)
            run(int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        abort_test();
        run(3, 0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqrt_controller.md
SQRT_CONTROLLER -- requirements
Module: sqrt_controller

Interface
REQ-001 SHALL have parameter MAX_ITER, default 16, meaning the iteration limit (legal 1..31).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_i, input, 1 bit: begin one square-root operation; data is on the register-file write-data mux external leg.
REQ-005 SHALL have port alu_done_i, input, 1 bit: FP ALU result valid this cycle.
REQ-006 SHALL have port converged_i, input, 1 bit: comparator output |RDA| < RDB.
REQ-007 SHALL have ports addr_rda_o, addr_rdb_o and addr_wr_o, output, 3 bits each: register-file read and write addresses.
REQ-008 SHALL have port WE_o, output, 1 bit: register-file write enable.
REQ-009 SHALL have port sel_ext_o, output, 1 bit: write-data mux select, 1 = external operand, 0 = ALU result.
REQ-010 SHALL have port alu_op_o, output, 2 bits: ADD=00, SUB=01, MUL=10, DIV=11.
REQ-011 SHALL have port alu_start_o, output, 1 bit: one-cycle ALU launch pulse.
REQ-012 SHALL have ports busy_o and done_o, output, 1 bit each: busy flag and one-cycle completion pulse.
REQ-013 SHALL have port iter_o, output, 5 bits: current iteration index.

Function
REQ-014 SHALL use this register map: r0=0.0, r1=S, r2=x_n, r3=temp, r4=x_new, r5=2.0, r6=0.01, r7=diff; SHALL never write r0, r5 or r6.
REQ-015 SHALL implement the states IDLE, LOAD_S, LOAD_X, ISSUE, WAIT, CHECK and DONE.
REQ-016 IDLE: when start_i=1, SHALL go to LOAD_S; start_i SHALL be ignored in every other state.
REQ-017 LOAD_S: SHALL drive WE_o=1, sel_ext_o=1, addr_wr_o=1 for one cycle, then go to LOAD_X.
REQ-018 LOAD_X: SHALL drive WE_o=1, sel_ext_o=1, addr_wr_o=2 for one cycle (x0=S), then clear step and iter and go to ISSUE.
REQ-019 SHALL sequence steps 0..4 as follows: 0 DIV r1,r2->r3; 1 ADD r2,r3->r3; 2 DIV r3,r5->r4; 3 SUB r4,r2->r7; 4 ADD r4,r0->r2.
REQ-020 ISSUE: SHALL drive alu_start_o=1 for exactly one cycle with the step's addresses and op, then go to WAIT.
REQ-021 WAIT: SHALL hold the same addresses and op; in the cycle alu_done_i=1 it SHALL drive WE_o=1 with sel_ext_o=0.
REQ-022 On leaving WAIT, SHALL go to ISSUE with step+1 if step<4, else to CHECK.
REQ-023 alu_done_i SHALL be ignored outside WAIT, including in the ISSUE cycle itself.
REQ-024 CHECK: SHALL drive addr_rda_o=7, addr_rdb_o=6 and WE_o=0 for one cycle, and sample converged_i.
REQ-025 From CHECK, SHALL go to DONE if converged_i=1 or iter=MAX_ITER-1; otherwise it SHALL increment iter, set step=0 and go to ISSUE.
REQ-026 DONE: SHALL drive done_o=1 and addr_rda_o=2 (result on RDA) for one cycle, then go to IDLE.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 WE_o SHALL be 0 in all states and cycles not named above.
REQ-029 In IDLE, all address outputs SHALL be 0.
REQ-030 The minimum latency SHALL be start to done = 2 + 5*(1+L) + 1 + 1 cycles per iteration, where L is the ALU latency in cycles.

Reset
REQ-031 While rst=1, the block SHALL hold state=IDLE, step=0 and iter=0.
REQ-032 While rst=1, all outputs SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately with no further WE_o; done_o SHALL not pulse.

Structure
REQ-034 A shared package SHALL hold the ALU opcode constants, register-index constants (R_ZERO..R_DIFF), the state enumeration and the MAX_ITER default.
REQ-035 The step-to-{rda, rdb, wr, op} mapping SHALL be one combinational sub-module, sqrt_step_decode.

Verification
REQ-036 rst mid-WAIT -> state IDLE at once, busy_o=0, no WE_o in any following cycle.
REQ-037 S=0x40800000 (4.0), ALU model L=3, converged_i=1 at the first CHECK -> WE_o targets sequence 1,2,3,3,4,7,2; done_o in cycle 2+20+1+1=24.
REQ-038 converged_i held 0, MAX_ITER=3 -> exactly 3 CHECK visits, iter_o 0,1,2, done_o after the third CHECK.
REQ-039 start_i pulsed while busy -> no effect on the sequence; a second start one cycle after done_o -> a clean new run.
REQ-040 Spurious alu_done_i in the ISSUE cycle, then a real alu_done_i 2 cycles later -> exactly one WE_o, on the real done.
REQ-041 Across all runs, assert that addr_wr_o is never in {0,5,6} whenever WE_o=1.
